dma_irq_status: RTL and testbench

- Hardware-set, software-cleared interrupt status block for the DMA register file.
- It is the counterpart of the masked self-clearing command register.
  - That register turns software writes into one-cycle pulses toward hardware.
  - This block turns one-cycle hardware event pulses into sticky status bits that software reads and clears with the same masked write format (upper half = mask, lower half = data).
- It adds per-bit overflow flags, an interrupt-enable register and interrupt coalescing (count threshold plus timeout) that drives the single DMA interrupt line.

---
 rtl/dma_irq_status.sv | 118 +++++++++++
 tb/tb_dma_irq_status.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dma_irq_status.sv
// DMA interrupt status: hardware-set, software-cleared sticky bits with overflow
// flags, interrupt enables and count/timeout coalescing of the single irq line.
module dma_irq_status #(
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 8,
    parameter int TMR_W   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NUM_EVT-1:0]   evt_i,
    input  logic                 sts_wr_en,
    input  logic [2*NUM_EVT-1:0] sts_wdata,
    input  logic                 ier_wr_en,
    input  logic [NUM_EVT-1:0]   ier_wdata,
    input  logic [CNT_W-1:0]     coal_thresh,
    input  logic [TMR_W-1:0]     coal_timeout,
    output logic [NUM_EVT-1:0]   status_o,
    output logic [NUM_EVT-1:0]   ovf_o,
    output logic [NUM_EVT-1:0]   ier_o,
    output logic                 irq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COALESCE,
        S_ASSERT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [TMR_W-1:0]   tmr, tmr_nxt, tmr_inc;
    logic [NUM_EVT-1:0] clr, status_nxt, ovf_nxt, ier_nxt;
    logic               pend_en, pend_en_nxt, hit, thresh_low, coal_done;

    // A bit clears only when both its mask and data bits are set in the write.
    assign clr = sts_wr_en ? (sts_wdata[2*NUM_EVT-1:NUM_EVT] & sts_wdata[NUM_EVT-1:0])
                           : '0;

    assign status_nxt  = (status_o & ~clr) | evt_i;
    assign ovf_nxt     = (evt_i & status_o & ~clr) | (ovf_o & ~clr);
    assign ier_nxt     = ier_wr_en ? ier_wdata : ier_o;
    assign pend_en_nxt = |(status_nxt & ier_nxt);
    assign pend_en     = |(status_o & ier_o);
    assign hit         = |(evt_i & ier_o);

    assign cnt_inc    = (cnt == '1) ? cnt : cnt + {{(CNT_W-1){1'b0}}, hit};
    assign tmr_inc    = (tmr == '1) ? tmr : tmr + TMR_W'(1);
    assign thresh_low = (coal_thresh <= CNT_W'(1));
    assign coal_done  = (cnt_inc >= coal_thresh) ||
                        ((coal_timeout != '0) && (tmr_inc >= coal_timeout));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        tmr_nxt   = tmr;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                tmr_nxt = '0;
                // pend_en covers an enable written while a status bit was already pending.
                if (hit || pend_en) begin
                    if (thresh_low) begin
                        state_nxt = S_ASSERT;
                    end else begin
                        state_nxt = S_COALESCE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_COALESCE: begin
                cnt_nxt = cnt_inc;
                tmr_nxt = tmr_inc;
                if (!pend_en_nxt) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else if (coal_done) begin
                    state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (!pend_en_nxt) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                tmr_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tmr      <= '0;
            status_o <= '0;
            ovf_o    <= '0;
            ier_o    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tmr      <= tmr_nxt;
            status_o <= status_nxt;
            ovf_o    <= ovf_nxt;
            ier_o    <= ier_nxt;
        end
    end

    assign irq_o = (state == S_ASSERT);

endmodule

// File: tb/tb_dma_irq_status.sv
// Directed bench for dma_irq_status: expected outputs are queued per driven cycle
// and popped/compared one time unit after the following rising edge.
module tb_dma_irq_status;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [7:0]  evt_i;
    logic        sts_wr_en;
    logic [15:0] sts_wdata;
    logic        ier_wr_en;
    logic [7:0]  ier_wdata;
    logic [7:0]  coal_thresh;
    logic [15:0] coal_timeout;
    logic [7:0]  status_o;
    logic [7:0]  ovf_o;
    logic [7:0]  ier_o;
    logic        irq_o;

    typedef struct {
        string      tag;
        logic [7:0] st;
        logic [7:0] ov;
        logic [7:0] ie;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    dma_irq_status #(.NUM_EVT(8), .CNT_W(8), .TMR_W(16)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .evt_i        (evt_i),
        .sts_wr_en    (sts_wr_en),
        .sts_wdata    (sts_wdata),
        .ier_wr_en    (ier_wr_en),
        .ier_wdata    (ier_wdata),
        .coal_thresh  (coal_thresh),
        .coal_timeout (coal_timeout),
        .status_o     (status_o),
        .ovf_o        (ovf_o),
        .ier_o        (ier_o),
        .irq_o        (irq_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go through the scoreboard.
    task automatic step(input logic [7:0] evt, input logic swe, input logic [15:0] swd,
                        input logic iwe, input logic [7:0] iwd,
                        input logic [7:0] e_st, input logic [7:0] e_ov,
                        input logic [7:0] e_ie, input logic e_irq, input string tag);
        exp_t e;
        exp_t got;
        evt_i     = evt;
        sts_wr_en = swe;
        sts_wdata = swd;
        ier_wr_en = iwe;
        ier_wdata = iwd;
        e.tag = tag;
        e.st  = e_st;
        e.ov  = e_ov;
        e.ie  = e_ie;
        e.irq = e_irq;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        evt_i     = '0;
        sts_wr_en = 1'b0;
        sts_wdata = '0;
        ier_wr_en = 1'b0;
        ier_wdata = '0;
        got = sb.pop_front();
        check({got.tag, ".status"}, status_o, got.st);
        check({got.tag, ".ovf"}, ovf_o, got.ov);
        check({got.tag, ".ier"}, ier_o, got.ie);
        check({got.tag, ".irq"}, {7'b0, irq_o}, {7'b0, got.irq});
    endtask

    task automatic idle(input int n, input logic [7:0] e_st, input logic [7:0] e_ov,
                        input logic [7:0] e_ie, input logic e_irq, input string tag);
        for (int i = 0; i < n; i++)
            step(8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, e_st, e_ov, e_ie, e_irq, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        evt_i        = '0;
        sts_wr_en    = 1'b0;
        sts_wdata    = '0;
        ier_wr_en    = 1'b0;
        ier_wdata    = '0;
        coal_thresh  = 8'd1;
        coal_timeout = 16'd0;

        // Reset held for two cycles
        idle(2, 8'h00, 8'h00, 8'h00, 1'b0, "reset");
        rst = 1'b0;

        // Single event with threshold 1: irq one edge after the event
        step(8'h00, 1'b0, 16'h0000, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, "ier01");
        step(8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1, "single_evt");
        step(8'h00, 1'b1, 16'h0101, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, "single_clr");

        // Masked write-1-to-clear with interrupts disabled
        step(8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "ier00");
        step(8'h0F, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h0F, 8'h00, 8'h00, 1'b0, "set_0f");
        step(8'h00, 1'b1, 16'h0303, 1'b0, 8'h00, 8'h0C, 8'h00, 8'h00, 1'b0, "w1c_0303");
        step(8'h00, 1'b1, 16'h0004, 1'b0, 8'h00, 8'h0C, 8'h00, 8'h00, 1'b0, "w1c_mask0");

        // Set/clear collision, then overflow set and clear
        step(8'h04, 1'b1, 16'h0404, 1'b0, 8'h00, 8'h0C, 8'h00, 8'h00, 1'b0, "collide");
        step(8'h04, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h0C, 8'h04, 8'h00, 1'b0, "ovf_set");
        step(8'h00, 1'b1, 16'h0404, 1'b0, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0, "ovf_clr");
        step(8'h00, 1'b1, 16'h0808, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "clr_08");

        // Count coalescing: threshold 4, events on cycles 0,3,5,9
        coal_thresh  = 8'd4;
        coal_timeout = 16'd0;
        step(8'h00, 1'b0, 16'h0000, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, "ierFF");
        step(8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h01, 8'h00, 8'hFF, 1'b0, "cnt_ev0");
        idle(2, 8'h01, 8'h00, 8'hFF, 1'b0, "cnt_gap1");
        step(8'h02, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h03, 8'h00, 8'hFF, 1'b0, "cnt_ev3");
        idle(1, 8'h03, 8'h00, 8'hFF, 1'b0, "cnt_gap2");
        step(8'h04, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h07, 8'h00, 8'hFF, 1'b0, "cnt_ev5");
        idle(3, 8'h07, 8'h00, 8'hFF, 1'b0, "cnt_gap3");
        step(8'h08, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h0F, 8'h00, 8'hFF, 1'b1, "cnt_ev9");
        idle(1, 8'h0F, 8'h00, 8'hFF, 1'b1, "cnt_hold");
        step(8'h00, 1'b1, 16'hFFFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "cnt_clr");
        idle(2, 8'h00, 8'h00, 8'hFF, 1'b0, "cnt_idle");

        // Timeout coalescing: irq exactly 20 edges after COALESCE entry
        coal_thresh  = 8'd10;
        coal_timeout = 16'd20;
        step(8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h01, 8'h00, 8'hFF, 1'b0, "tmo_entry");
        idle(19, 8'h01, 8'h00, 8'hFF, 1'b0, "tmo_wait");
        idle(1, 8'h01, 8'h00, 8'hFF, 1'b1, "tmo_rise");
        step(8'h00, 1'b1, 16'h0101, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "tmo_clr");

        // Timeout aborted by clearing at cycle 10
        step(8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h01, 8'h00, 8'hFF, 1'b0, "abort_entry");
        idle(9, 8'h01, 8'h00, 8'hFF, 1'b0, "abort_wait");
        step(8'h00, 1'b1, 16'h0101, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "abort_clr");
        idle(15, 8'h00, 8'h00, 8'hFF, 1'b0, "abort_quiet");

        // Disabled source, then late enable: irq two edges after the ier write
        coal_thresh  = 8'd1;
        coal_timeout = 16'd0;
        step(8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "late_ier0");
        step(8'h80, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h80, 8'h00, 8'h00, 1'b0, "disabled_evt");
        step(8'h00, 1'b0, 16'h0000, 1'b1, 8'h80, 8'h80, 8'h00, 8'h80, 1'b0, "late_ier80");
        idle(2, 8'h80, 8'h00, 8'h80, 1'b1, "late_irq");

        // Reset while asserting: everything clears, no residual irq
        rst = 1'b1;
        step(8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "rst_mid");
        rst = 1'b0;
        idle(1, 8'h00, 8'h00, 8'h00, 1'b0, "rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
